// File: rtl/xpb_pkg.sv
// Shared constants, state encoding and helpers for the programmable xpb lookup table.
package xpb_pkg;

    localparam int unsigned WORD_BITS_DEF = 1024;
    localparam int unsigned IDX_BITS_DEF  = 5;
    localparam int unsigned NUM_SEGS_DEF  = 16;
    localparam int unsigned NUM_CH_DEF    = 4;
    localparam int unsigned PAR_SLICE     = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } xpb_state_e;

    function automatic int unsigned xpb_entries(input int unsigned idx_bits);
        return 32'd1 << idx_bits;
    endfunction

    function automatic int unsigned xpb_ld_beats(input int unsigned num_segs, input int unsigned idx_bits);
        return num_segs * (xpb_entries(idx_bits) - 1);
    endfunction

    function automatic int unsigned xpb_par_slices(input int unsigned word_bits);
        return (word_bits + PAR_SLICE - 1) / PAR_SLICE;
    endfunction

    function automatic logic xpb_slice_parity(input logic [PAR_SLICE-1:0] slice);
        return ^slice;
    endfunction

endpackage

// File: rtl/xpb_lut_bank.sv
// One copy of the xpb table storage: simple dual-port RAM, one write and one registered read port.
module xpb_lut_bank #(
    parameter int unsigned DATA_W = 1024,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/xpb_lut_ram.sv
// Run-time loadable xpb constant tables with NUM_CH pipelined lookup channels (latency 2).
// Optional per-64-bit-slice even parity when XPB_LUT_PARITY_EN is defined (adds rd_perr).
module xpb_lut_ram
    import xpb_pkg::*;
#(
    parameter int unsigned WORD_BITS = WORD_BITS_DEF,
    parameter int unsigned IDX_BITS  = IDX_BITS_DEF,
    parameter int unsigned NUM_SEGS  = NUM_SEGS_DEF,
    parameter int unsigned NUM_CH    = NUM_CH_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ld_start,
    input  logic                                ld_valid,
    output logic                                ld_ready,
    input  logic [WORD_BITS-1:0]                ld_data,
    output logic                                tbl_ready,
    input  logic [NUM_CH-1:0]                   rd_valid,
    input  logic [NUM_CH*$clog2(NUM_SEGS)-1:0]  rd_seg,
    input  logic [NUM_CH*IDX_BITS-1:0]          rd_idx,
    output logic [NUM_CH-1:0]                   rd_out_vld,
    output logic [NUM_CH-1:0]                   rd_miss,
`ifdef XPB_LUT_PARITY_EN
    output logic [NUM_CH-1:0]                   rd_perr,
`endif
    output logic [NUM_CH*WORD_BITS-1:0]         rd_data
);

    localparam int unsigned SEG_W   = $clog2(NUM_SEGS);
    localparam int unsigned ADDR_W  = SEG_W + IDX_BITS;
    localparam int unsigned ENTRIES = xpb_entries(IDX_BITS);
`ifdef XPB_LUT_PARITY_EN
    localparam int unsigned PAR_W   = xpb_par_slices(WORD_BITS);
`else
    localparam int unsigned PAR_W   = 0;
`endif
    localparam int unsigned DATA_W  = WORD_BITS + PAR_W;

    xpb_state_e          state_q, state_d;
    logic [SEG_W-1:0]    ld_seg_q, ld_seg_d;
    logic [IDX_BITS-1:0] ld_idx_q, ld_idx_d;
    logic                ld_we_c;
    logic                last_beat_c;
    logic [DATA_W-1:0]   ld_wdata_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            ld_seg_q  <= '0;
            ld_idx_q  <= IDX_BITS'(1);
            tbl_ready <= 1'b0;
            ld_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_seg_q  <= ld_seg_d;
            ld_idx_q  <= ld_idx_d;
            tbl_ready <= (state_d == READY);
            ld_ready  <= (state_d == LOAD);
        end
    end

    // Seg-major load address walk; idx 0 is never stored, ld_start wins over a beat.
    always_comb begin
        state_d     = state_q;
        ld_seg_d    = ld_seg_q;
        ld_idx_d    = ld_idx_q;
        ld_we_c     = 1'b0;
        last_beat_c = (ld_seg_q == SEG_W'(NUM_SEGS - 1)) && (ld_idx_q == IDX_BITS'(ENTRIES - 1));
        if (ld_start) begin
            state_d  = LOAD;
            ld_seg_d = '0;
            ld_idx_d = IDX_BITS'(1);
        end else if (state_q == LOAD && ld_valid) begin
            ld_we_c = 1'b1;
            if (last_beat_c) begin
                state_d = READY;
            end else if (ld_idx_q == IDX_BITS'(ENTRIES - 1)) begin
                ld_seg_d = ld_seg_q + 1'b1;
                ld_idx_d = IDX_BITS'(1);
            end else begin
                ld_idx_d = ld_idx_q + 1'b1;
            end
        end
    end

`ifdef XPB_LUT_PARITY_EN
    logic [PAR_W*PAR_SLICE-1:0] ld_pad_c;
    logic [PAR_W-1:0]           ld_par_c;

    always_comb begin
        ld_pad_c = (PAR_W*PAR_SLICE)'(ld_data);
        ld_par_c = '0;
        for (int k = 0; k < int'(PAR_W); k++) begin
            ld_par_c[k] = xpb_slice_parity(ld_pad_c[k*PAR_SLICE +: PAR_SLICE]);
        end
    end
    assign ld_wdata_c = {ld_par_c, ld_data};
`else
    assign ld_wdata_c = ld_data;
`endif

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        logic [SEG_W-1:0]     seg_c;
        logic [IDX_BITS-1:0]  idx_c;
        logic [DATA_W-1:0]    q;
        logic                 v1_q, miss1_q, zero1_q;
        logic                 vld_q, miss_q;
        logic [WORD_BITS-1:0] data_q;

        assign seg_c = rd_seg[c*SEG_W +: SEG_W];
        assign idx_c = rd_idx[c*IDX_BITS +: IDX_BITS];

        xpb_lut_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (ld_we_c),
            .waddr ({ld_seg_q, ld_idx_q}),
            .wdata (ld_wdata_c),
            .re    (rd_valid[c] && (idx_c != '0)),
            .raddr ({seg_c, idx_c}),
            .rdata (q)
        );

        // Stage 1 tracks the request alongside the RAM read; stage 2 is the output register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q    <= 1'b0;
                miss1_q <= 1'b0;
                zero1_q <= 1'b0;
                vld_q   <= 1'b0;
                miss_q  <= 1'b0;
                data_q  <= '0;
            end else begin
                v1_q    <= rd_valid[c];
                miss1_q <= !tbl_ready;
                zero1_q <= !tbl_ready || (idx_c == '0) ||
                           ({1'b0, seg_c} >= (SEG_W+1)'(NUM_SEGS));
                vld_q   <= v1_q;
                miss_q  <= v1_q && miss1_q;
                if (v1_q) begin
                    data_q <= zero1_q ? '0 : q[WORD_BITS-1:0];
                end
            end
        end

        assign rd_out_vld[c]                      = vld_q;
        assign rd_miss[c]                         = miss_q;
        assign rd_data[c*WORD_BITS +: WORD_BITS]  = data_q;

`ifdef XPB_LUT_PARITY_EN
        logic [PAR_W*PAR_SLICE-1:0] rd_pad_c;
        logic                       perr_c;
        logic                       perr_q;

        always_comb begin
            rd_pad_c = (PAR_W*PAR_SLICE)'(q[WORD_BITS-1:0]);
            perr_c   = 1'b0;
            for (int k = 0; k < int'(PAR_W); k++) begin
                perr_c = perr_c | (xpb_slice_parity(rd_pad_c[k*PAR_SLICE +: PAR_SLICE]) ^ q[WORD_BITS+k]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                perr_q <= 1'b0;
            end else begin
                perr_q <= v1_q && !zero1_q && perr_c;
            end
        end

        assign rd_perr[c] = perr_q;
`endif
    end

endmodule

// File: tb/tb_xpb_lut_ram.sv
// Self-checking bench for xpb_lut_ram (16-bit words, 2 segments of 4 entries, 2 channels).
module tb_xpb_lut_ram;

    localparam int unsigned W     = 16;
    localparam int unsigned IB    = 2;
    localparam int unsigned NS    = 2;
    localparam int unsigned NC    = 2;
    localparam int unsigned SW    = 1;
    localparam int unsigned E     = 4;
    localparam int unsigned BEATS = NS * (E - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ld_start, ld_valid, ld_ready, tbl_ready;
    logic [W-1:0]      ld_data;
    logic [NC-1:0]     rd_valid, rd_out_vld, rd_miss;
    logic [NC*SW-1:0]  rd_seg;
    logic [NC*IB-1:0]  rd_idx;
    logic [NC*W-1:0]   rd_data;
`ifdef XPB_LUT_PARITY_EN
    logic [NC-1:0]     rd_perr;
`endif

    always #5 clk = ~clk;

    xpb_lut_ram #(
        .WORD_BITS (W),
        .IDX_BITS  (IB),
        .NUM_SEGS  (NS),
        .NUM_CH    (NC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .tbl_ready  (tbl_ready),
        .rd_valid   (rd_valid),
        .rd_seg     (rd_seg),
        .rd_idx     (rd_idx),
        .rd_out_vld (rd_out_vld),
        .rd_miss    (rd_miss),
`ifdef XPB_LUT_PARITY_EN
        .rd_perr    (rd_perr),
`endif
        .rd_data    (rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: table contents, loader progress and last delivered word per channel.
    logic [W-1:0] m_mem [NS][E];
    int           m_state;   // 0 empty, 1 loading, 2 ready
    int           m_cnt;
    logic [W-1:0] m_last [NC];

    typedef struct packed {
        logic [NC-1:0]   vld;
        logic [NC-1:0]   miss;
        logic [NC*W-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic [NC-1:0]    rv;
        logic [NC*SW-1:0] rs;
        logic [NC*IB-1:0] ri;
        logic [NC-1:0]    vld;
        logic [NC-1:0]    miss;
        logic [NC*W-1:0]  d;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs, predict, advance, then compare against the request two cycles old.
    task automatic cyc(input logic st, input logic lv, input logic [W-1:0] ld,
                       input logic [NC-1:0] rv, input logic [NC*SW-1:0] rs, input logic [NC*IB-1:0] ri);
        exp_t e;
        int   s, i;
        ld_start = st;
        ld_valid = lv;
        ld_data  = ld;
        rd_valid = rv;
        rd_seg   = rs;
        rd_idx   = ri;
        e.vld  = rv;
        e.miss = '0;
        for (int c = 0; c < int'(NC); c++) begin
            if (rv[c]) begin
                s = int'(rs[c*SW +: SW]);
                i = int'(ri[c*IB +: IB]);
                if (m_state != 2) begin
                    e.miss[c] = 1'b1;
                    m_last[c] = '0;
                end else begin
                    m_last[c] = (i == 0 || s >= int'(NS)) ? '0 : m_mem[s][i];
                end
            end
        end
        e.d = {m_last[1], m_last[0]};
        if (st) begin
            m_state = 1;
            m_cnt   = 0;
        end else if (m_state == 1 && lv) begin
            m_mem[m_cnt / int'(E - 1)][m_cnt % int'(E - 1) + 1] = ld;
            m_cnt++;
            if (m_cnt == int'(BEATS)) m_state = 2;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("tbl_ready", 64'(tbl_ready), 64'(m_state == 2));
        chk("ld_ready", 64'(ld_ready), 64'(m_state == 1));
`ifdef XPB_LUT_PARITY_EN
        chk("rd_perr", 64'(rd_perr), 64'(0));
`endif
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            chk("rd_out_vld", 64'(rd_out_vld), 64'(e.vld));
            chk("rd_miss", 64'(rd_miss), 64'(e.miss));
            chk("rd_data", 64'(rd_data), 64'(e.d));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic load_all(input logic [W-1:0] base, input logic gaps);
        cyc(1'b1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < int'(BEATS); k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 16'hbeef, NC'($urandom), '0, '0);
            end
            if (k == int'(BEATS) - 1) chk("tbl_ready_before_last", 64'(tbl_ready), 64'(0));
            cyc(1'b0, 1'b1, base + W'(k), NC'($urandom), NC'($urandom), (NC*IB)'($urandom));
        end
        chk("tbl_ready_after_last", 64'(tbl_ready), 64'(1));
        chk("ld_ready_after_last", 64'(ld_ready), 64'(0));
    endtask

    task automatic reset_model();
        m_state = 0;
        m_cnt   = 0;
        exp_q.delete();
        for (int c = 0; c < int'(NC); c++) m_last[c] = '0;
    endtask

    logic [W-1:0] b2b [4];

    initial begin
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        rd_valid = '0;   rd_seg = '0;     rd_idx = '0;
        reset_model();
        for (int s = 0; s < int'(NS); s++)
            for (int i = 0; i < int'(E); i++) m_mem[s][i] = '0;

        tbl[0] = '{rv: 2'b11, rs: 2'b01, ri: 4'b0111, vld: 2'b11, miss: 2'b00, d: {16'h1001, 16'h1006}};
        tbl[1] = '{rv: 2'b01, rs: 2'b00, ri: 4'b0000, vld: 2'b01, miss: 2'b00, d: {16'h1001, 16'h0000}};
        tbl[2] = '{rv: 2'b10, rs: 2'b10, ri: 4'b1000, vld: 2'b10, miss: 2'b00, d: {16'h1005, 16'h0000}};
        tbl[3] = '{rv: 2'b11, rs: 2'b10, ri: 4'b0110, vld: 2'b11, miss: 2'b00, d: {16'h1004, 16'h1002}};
        tbl[4] = '{rv: 2'b00, rs: 2'b00, ri: 4'b0000, vld: 2'b00, miss: 2'b00, d: {16'h1004, 16'h1002}};
        b2b[0] = 16'h0000; b2b[1] = 16'h1001; b2b[2] = 16'h1002; b2b[3] = 16'h1003;

        // Reset values
        #2 rst_n = 1'b0;
        #10;
        chk("reset_tbl_ready", 64'(tbl_ready), 64'(0));
        chk("reset_ld_ready", 64'(ld_ready), 64'(0));
        chk("reset_rd_out_vld", 64'(rd_out_vld), 64'(0));
        chk("reset_rd_miss", 64'(rd_miss), 64'(0));
        chk("reset_rd_data", 64'(rd_data), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lookup before any load misses on both channels; beats are ignored while EMPTY
        cyc(1'b0, 1'b1, 16'hdead, 2'b11, 2'b11, 4'b1111);
        idle();
        chk("preload_vld", 64'(rd_out_vld), 64'(2'b11));
        chk("preload_miss", 64'(rd_miss), 64'(2'b11));
        chk("preload_data", 64'(rd_data), 64'(0));

        load_all(16'h1001, 1'b1);

        for (int v = 0; v < 5; v++) begin
            cyc(1'b0, 1'b0, '0, tbl[v].rv, tbl[v].rs, tbl[v].ri);
            idle();
            chk($sformatf("vec%0d_vld", v), 64'(rd_out_vld), 64'(tbl[v].vld));
            chk($sformatf("vec%0d_miss", v), 64'(rd_miss), 64'(tbl[v].miss));
            chk($sformatf("vec%0d_data", v), 64'(rd_data), 64'(tbl[v].d));
        end

        // Back-to-back lookups idx 0..3 on ch0, seg 0
        for (int j = 0; j < 6; j++) begin
            if (j < 4) cyc(1'b0, 1'b0, '0, 2'b01, 2'b00, (NC*IB)'(j));
            else       idle();
            if (j >= 1 && j <= 4) chk($sformatf("b2b%0d_data", j - 1), 64'(rd_data[W-1:0]), 64'(b2b[j-1]));
        end

        // Partial load abandoned by ld_start, then full reload
        cyc(1'b1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 16'h2001 + W'(k), 2'b11, 2'b01, 4'b0111);
        load_all(16'h2001, 1'b0);
        cyc(1'b0, 1'b0, '0, 2'b11, 2'b01, 4'b0111);
        idle();
        chk("reload_seg1_idx3", 64'(rd_data[W-1:0]), 64'(16'h2006));
        chk("reload_seg0_idx1", 64'(rd_data[2*W-1:W]), 64'(16'h2001));

        // Random traffic with occasional reloads
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom), W'($urandom),
                NC'($urandom), (NC*SW)'($urandom), (NC*IB)'($urandom));
        end

        // Reset mid-load with a lookup in flight
        load_all(16'h4001, 1'b0);
        cyc(1'b0, 1'b0, '0, 2'b11, 2'b01, 4'b0111);
        cyc(1'b1, 1'b0, '0, '0, '0, '0);
        cyc(1'b0, 1'b1, 16'h5001, '0, '0, '0);
        cyc(1'b0, 1'b1, 16'h5002, 2'b11, 2'b10, 4'b0101);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_tbl_ready", 64'(tbl_ready), 64'(0));
        chk("rst_async_ld_ready", 64'(ld_ready), 64'(0));
        chk("rst_async_vld", 64'(rd_out_vld), 64'(0));
        chk("rst_async_miss", 64'(rd_miss), 64'(0));
        chk("rst_async_data", 64'(rd_data), 64'(0));
        ld_start = 1'b0; ld_valid = 1'b0; rd_valid = '0;
        reset_model();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 16'h6001, 2'b11, 2'b11, 4'b1111);
        idle();
        chk("post_rst_miss", 64'(rd_miss), 64'(2'b11));
        chk("post_rst_vld", 64'(rd_out_vld), 64'(2'b11));
        idle();

`ifdef XPB_LUT_PARITY_EN
        // Corrupt one stored bit of seg1 idx2 in the ch0 copy only
        load_all(16'h3001, 1'b0);
        idle();
        idle();
        dut.g_ch[0].u_bank.mem[6][3] = ~dut.g_ch[0].u_bank.mem[6][3];
        rd_valid = 2'b11; rd_seg = 2'b11; rd_idx = 4'b1010;
        @(posedge clk); #1;
        rd_valid = '0;
        @(posedge clk); #1;
        chk("perr_flipped", 64'(rd_perr), 64'(2'b01));
        chk("perr_ch0_data", 64'(rd_data[W-1:0]), 64'(16'h300d));
        chk("perr_ch1_data", 64'(rd_data[2*W-1:W]), 64'(16'h3005));
        rd_valid = 2'b01; rd_seg = 2'b00; rd_idx = 4'b0001;
        @(posedge clk); #1;
        rd_valid = '0;
        @(posedge clk); #1;
        chk("perr_clean", 64'(rd_perr), 64'(2'b00));
        chk("perr_clean_data", 64'(rd_data[W-1:0]), 64'(16'h3001));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
